// File: rtl/pmp_pkg.sv
// Shared definitions for the PMP CSR responder.
// Contents: CSR window constants, CSR funct3 encodings, pmpcfg field
// positions and address-matching modes, responder FSM states, and the
// per-byte WARL filter applied to pmpcfg writes.
package pmp_pkg;

   localparam int unsigned PMPCFG_BASE  = 32'h3A0;
   localparam int unsigned PMPADDR_BASE = 32'h3B0;
   localparam int unsigned PMP_LAST     = 32'h3EF;

   typedef enum logic [2:0] {
      F3_ILL0 = 3'b000,
      F3_RW   = 3'b001,
      F3_RS   = 3'b010,
      F3_RC   = 3'b011,
      F3_ILL1 = 3'b100,
      F3_RWI  = 3'b101,
      F3_RSI  = 3'b110,
      F3_RCI  = 3'b111
   } csr_funct3_e;

   localparam int CFG_R    = 0;
   localparam int CFG_W    = 1;
   localparam int CFG_X    = 2;
   localparam int CFG_A_LO = 3;
   localparam int CFG_A_HI = 4;
   localparam int CFG_L    = 7;

   // Bits 6:5 of every cfg byte are reserved and always stored as zero.
   localparam logic [7:0] CFG_WMASK = 8'h9F;

   typedef enum logic [1:0] {
      A_OFF   = 2'b00,
      A_TOR   = 2'b01,
      A_NA4   = 2'b10,
      A_NAPOT = 2'b11
   } pmp_a_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } pmp_state_e;

   // A locked byte never changes; the reserved R=0/W=1 combination is
   // rejected by keeping the previous byte.
   function automatic logic [7:0] cfg_warl(logic [7:0] old_b, logic [7:0] new_b);
      if (old_b[CFG_L] || (!new_b[CFG_R] && new_b[CFG_W]))
         return old_b;
      return new_b & CFG_WMASK;
   endfunction

endpackage

// File: rtl/pmp_csr_regfile_if.sv
// CSR bus port between the issuer (master) and the PMP responder (slave).
// Request: pmp_reg_en strobe, pmp_reg_op {read, write}, pmp_funct3,
// pmp_csr_imm, pmp_rs1_val, pmp_addr. Response: pmp_rdata, pmp_rvalid,
// pmp_act_rsp, acknowledged by pmp_rrsp.
interface pmp_csr_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 32
);
   logic                  pmp_reg_en;
   logic [1:0]            pmp_reg_op;
   logic [2:0]            pmp_funct3;
   logic [4:0]            pmp_csr_imm;
   logic [REG_WIDTH-1:0]  pmp_rs1_val;
   logic [ADDR_WIDTH-1:0] pmp_addr;
   logic                  pmp_rrsp;
   logic [ADDR_WIDTH-1:0] pmp_rdata;
   logic                  pmp_rvalid;
   logic                  pmp_act_rsp;

   modport master (
      output pmp_reg_en, pmp_reg_op, pmp_funct3, pmp_csr_imm, pmp_rs1_val,
             pmp_addr, pmp_rrsp,
      input  pmp_rdata, pmp_rvalid, pmp_act_rsp
   );

   modport slave (
      input  pmp_reg_en, pmp_reg_op, pmp_funct3, pmp_csr_imm, pmp_rs1_val,
             pmp_addr, pmp_rrsp,
      output pmp_rdata, pmp_rvalid, pmp_act_rsp
   );
endinterface

// File: rtl/pmp_csr_alu.sv
// Combinational CSR read-modify-write datapath.
// Ports: funct3 / csr_imm / rs1_val select the operand and operation,
// old_val is the current CSR value, new_val the value to write,
// illegal flags the reserved funct3 encodings 000 and 100.
module pmp_csr_alu
   import pmp_pkg::*;
#(
   parameter int REG_WIDTH = 32
) (
   input  logic [2:0]           funct3,
   input  logic [4:0]           csr_imm,
   input  logic [REG_WIDTH-1:0] rs1_val,
   input  logic [REG_WIDTH-1:0] old_val,
   output logic [REG_WIDTH-1:0] new_val,
   output logic                 illegal
);

   logic [REG_WIDTH-1:0] operand;

   always_comb begin
      operand = funct3[2] ? REG_WIDTH'(csr_imm) : rs1_val;
      new_val = old_val;
      illegal = 1'b0;
      case (csr_funct3_e'(funct3))
         F3_RW, F3_RWI: new_val = operand;
         F3_RS, F3_RSI: new_val = old_val | operand;
         F3_RC, F3_RCI: new_val = old_val & ~operand;
         default:       illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pmp_csr_regfile.sv
// PMP CSR responder: holds pmpcfg/pmpaddr, executes CSR accesses and
// returns one registered response per request, held until pmp_rrsp.
// Ports: clk, rst (async, active high), bus (slave side of the CSR port),
// pmp_cfg_o (cfg byte i at [8i+7:8i]), pmp_addr_o (pmpaddr i).
//
// state  | meaning
// S_IDLE | waiting for pmp_reg_en; request executes on the accepting edge
// S_RESP | response valid and stable until pmp_rrsp
module pmp_csr_regfile
   import pmp_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int REG_WIDTH   = 32,
   parameter int PMP_ENTRIES = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   pmp_csr_regfile_if.slave                 bus,
   output logic [PMP_ENTRIES*8-1:0]         pmp_cfg_o,
   output logic [PMP_ENTRIES*REG_WIDTH-1:0] pmp_addr_o
);

   localparam int CFG_REGS = PMP_ENTRIES / 4;

   pmp_state_e            state_q, state_d;
   logic [7:0]            cfg_q  [PMP_ENTRIES];
   logic [REG_WIDTH-1:0]  addr_q [PMP_ENTRIES];
   logic [REG_WIDTH-1:0]  old_val, new_val;
   logic                  f3_illegal, in_window, illegal;
   logic                  accept, ack, wr_en;
   logic [PMP_ENTRIES-1:0] addr_locked;
   logic [ADDR_WIDTH-1:0] rdata_q;
   logic                  act_q;

   pmp_csr_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
      .funct3  (bus.pmp_funct3),
      .csr_imm (bus.pmp_csr_imm),
      .rs1_val (bus.pmp_rs1_val),
      .old_val (old_val),
      .new_val (new_val),
      .illegal (f3_illegal)
   );

   always_comb begin
      in_window = (bus.pmp_addr >= ADDR_WIDTH'(PMPCFG_BASE)) &&
                  (bus.pmp_addr <= ADDR_WIDTH'(PMP_LAST));
      illegal   = !in_window || f3_illegal;
      accept    = (state_q == S_IDLE) && bus.pmp_reg_en;
      ack       = (state_q == S_RESP) && bus.pmp_rrsp;
      wr_en     = accept && bus.pmp_reg_op[0] && !illegal;
   end

   // Only implemented registers decode; anything else in the window reads 0.
   always_comb begin
      old_val = '0;
      for (int k = 0; k < CFG_REGS; k++)
         if (bus.pmp_addr == ADDR_WIDTH'(PMPCFG_BASE + k))
            for (int b = 0; b < 4; b++)
               old_val[8*b +: 8] = cfg_q[4*k + b];
      for (int j = 0; j < PMP_ENTRIES; j++)
         if (bus.pmp_addr == ADDR_WIDTH'(PMPADDR_BASE + j))
            old_val = addr_q[j];
   end

   // pmpaddr i is also frozen when entry i+1 is a locked TOR region,
   // since it forms that region's lower bound.
   always_comb begin
      for (int i = 0; i < PMP_ENTRIES; i++)
         addr_locked[i] = cfg_q[i][CFG_L];
      for (int i = 0; i < PMP_ENTRIES - 1; i++)
         if (cfg_q[i+1][CFG_L] && (cfg_q[i+1][CFG_A_HI:CFG_A_LO] == A_TOR))
            addr_locked[i] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RESP;
         S_RESP:  if (ack)    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.pmp_rvalid  = (state_q == S_RESP);
      bus.pmp_rdata   = rdata_q;
      bus.pmp_act_rsp = act_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         act_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= (illegal || !bus.pmp_reg_op[1]) ? '0 : ADDR_WIDTH'(old_val);
         act_q   <= illegal;
      end else if (ack) begin
         rdata_q <= '0;
         act_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PMP_ENTRIES; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < CFG_REGS; k++)
            if (bus.pmp_addr == ADDR_WIDTH'(PMPCFG_BASE + k))
               for (int b = 0; b < 4; b++)
                  cfg_q[4*k + b] <= cfg_warl(cfg_q[4*k + b], new_val[8*b +: 8]);
         for (int j = 0; j < PMP_ENTRIES; j++)
            if ((bus.pmp_addr == ADDR_WIDTH'(PMPADDR_BASE + j)) && !addr_locked[j])
               addr_q[j] <= new_val;
      end
   end

   always_comb begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
         pmp_cfg_o[8*i +: 8]                 = cfg_q[i];
         pmp_addr_o[REG_WIDTH*i +: REG_WIDTH] = addr_q[i];
      end
   end

endmodule

// File: tb/tb_pmp_csr_regfile.sv
module tb_pmp_csr_regfile;

   localparam int AW = 32;
   localparam int RW = 32;
   localparam int NE = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NE*8-1:0]  pmp_cfg_o;
   logic [NE*RW-1:0] pmp_addr_o;

   int checks = 0;
   int errors = 0;

   pmp_csr_regfile_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

   pmp_csr_regfile #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .PMP_ENTRIES(NE)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .pmp_cfg_o  (pmp_cfg_o),
      .pmp_addr_o (pmp_addr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic [2:0]  f3;
      logic [4:0]  imm;
      logic [31:0] rs1;
      logic [1:0]  op;
      logic [31:0] rdata;
      logic        act;
      logic [31:0] cfg0;
      logic [31:0] addr0;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] imm,
                      input logic [31:0] rs1, input logic [1:0] op, input logic [31:0] rd,
                      input logic act, input logic [31:0] c0, input logic [31:0] a0);
      vec_t v;
      v.addr = a; v.f3 = f3; v.imm = imm; v.rs1 = rs1; v.op = op;
      v.rdata = rd; v.act = act; v.cfg0 = c0; v.addr0 = a0;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] imm,
                        input logic [31:0] rs1, input logic [1:0] op, input logic rrsp);
      bus.pmp_reg_en  = 1'b1;
      bus.pmp_addr    = {20'h0, a};
      bus.pmp_funct3  = f3;
      bus.pmp_csr_imm = imm;
      bus.pmp_rs1_val = rs1;
      bus.pmp_reg_op  = op;
      bus.pmp_rrsp    = rrsp;
   endtask

   initial begin
      bus.pmp_reg_en  = 1'b0;
      bus.pmp_reg_op  = 2'b00;
      bus.pmp_funct3  = 3'b000;
      bus.pmp_csr_imm = 5'h0;
      bus.pmp_rs1_val = '0;
      bus.pmp_addr    = '0;
      bus.pmp_rrsp    = 1'b1;

      //   addr    f3    imm    rs1           op     rdata         act  cfg0          addr0
      add(12'h3B0, 3'd1, 5'h00, 32'h1234_5678, 2'b11, 32'h0,        0, 32'h0,        32'h1234_5678);
      add(12'h3A0, 3'd6, 5'h1F, 32'h0,         2'b11, 32'h0,        0, 32'h1F,       32'h1234_5678);
      add(12'h3A0, 3'd2, 5'h00, 32'h0,         2'b10, 32'h1F,       0, 32'h1F,       32'h1234_5678);
      add(12'h3A0, 3'd1, 5'h00, 32'h0000_6502, 2'b11, 32'h1F,       0, 32'h051F,     32'h1234_5678);
      add(12'h3A0, 3'd7, 5'h04, 32'h0,         2'b11, 32'h051F,     0, 32'h051B,     32'h1234_5678);
      add(12'h3A0, 3'd1, 5'h00, 32'h88,        2'b11, 32'h051B,     0, 32'h88,       32'h1234_5678);
      add(12'h3A0, 3'd1, 5'h00, 32'h0,         2'b11, 32'h88,       0, 32'h88,       32'h1234_5678);
      add(12'h3B0, 3'd1, 5'h00, 32'hFFFF_FFFF, 2'b11, 32'h1234_5678, 0, 32'h88,      32'h1234_5678);
      add(12'h3F0, 3'd1, 5'h00, 32'h5,         2'b11, 32'h0,        1, 32'h88,       32'h1234_5678);
      add(12'h39F, 3'd2, 5'h00, 32'h0,         2'b10, 32'h0,        1, 32'h88,       32'h1234_5678);
      add(12'h3A0, 3'd4, 5'h00, 32'h0,         2'b11, 32'h0,        1, 32'h88,       32'h1234_5678);
      add(12'h3B0, 3'd0, 5'h00, 32'h0,         2'b11, 32'h0,        1, 32'h88,       32'h1234_5678);
      add(12'h3A4, 3'd1, 5'h00, 32'hFFFF,      2'b11, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3A4, 3'd2, 5'h00, 32'h0,         2'b10, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3A1, 3'd1, 5'h00, 32'h0000_8800, 2'b11, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3B4, 3'd1, 5'h00, 32'hAAAA,      2'b11, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3B4, 3'd2, 5'h00, 32'h0,         2'b10, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3A1, 3'd2, 5'h00, 32'h0,         2'b10, 32'h0000_8800, 0, 32'h88,      32'h1234_5678);
      add(12'h3B3, 3'd1, 5'h00, 32'h55,        2'b11, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3B3, 3'd1, 5'h00, 32'h66,        2'b01, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3B3, 3'd2, 5'h00, 32'h0,         2'b10, 32'h66,       0, 32'h88,       32'h1234_5678);
      add(12'h3B3, 3'd1, 5'h00, 32'h77,        2'b10, 32'h66,       0, 32'h88,       32'h1234_5678);
      add(12'h3B3, 3'd5, 5'h1C, 32'hFFFF_FFFF, 2'b11, 32'h66,       0, 32'h88,       32'h1234_5678);
      add(12'h3B3, 3'd2, 5'h00, 32'h0,         2'b10, 32'h1C,       0, 32'h88,       32'h1234_5678);
      add(12'h3C0, 3'd2, 5'h00, 32'h0,         2'b10, 32'h0,        0, 32'h88,       32'h1234_5678);
      add(12'h3EF, 3'd1, 5'h00, 32'h1,         2'b11, 32'h0,        0, 32'h88,       32'h1234_5678);

      // reset state
      #2;
      chk("rst_rvalid", 32'(bus.pmp_rvalid), 32'h0);
      chk("rst_rdata", bus.pmp_rdata, 32'h0);
      chk("rst_act", 32'(bus.pmp_act_rsp), 32'h0);
      chk("rst_cfg0", pmp_cfg_o[31:0], 32'h0);
      chk("rst_addr0", pmp_addr_o[31:0], 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // table vectors, ack in the first response cycle
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].addr, vecs[i].f3, vecs[i].imm, vecs[i].rs1, vecs[i].op, 1'b1);
         @(negedge clk);
         bus.pmp_reg_en = 1'b0;
         chk($sformatf("v%0d_rvalid", i), 32'(bus.pmp_rvalid), 32'h1);
         chk($sformatf("v%0d_rdata", i), bus.pmp_rdata, vecs[i].rdata);
         chk($sformatf("v%0d_act", i), 32'(bus.pmp_act_rsp), 32'(vecs[i].act));
         @(negedge clk);
         chk($sformatf("v%0d_rvalid_off", i), 32'(bus.pmp_rvalid), 32'h0);
         chk($sformatf("v%0d_rdata_off", i), bus.pmp_rdata, 32'h0);
         chk($sformatf("v%0d_cfg0", i), pmp_cfg_o[31:0], vecs[i].cfg0);
         chk($sformatf("v%0d_addr0", i), pmp_addr_o[31:0], vecs[i].addr0);
      end
      chk("cfg1_export", pmp_cfg_o[63:32], 32'h0000_8800);
      chk("addr3_export", pmp_addr_o[4*RW-1:3*RW], 32'h1C);
      chk("addr4_export", pmp_addr_o[5*RW-1:4*RW], 32'h0);

      // hold until ack, with a stray request strobe during the response
      @(negedge clk);
      drive(12'h3A0, 3'd2, 5'h0, 32'h0, 2'b10, 1'b0);
      @(negedge clk);
      bus.pmp_reg_en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("hold%0d_rvalid", c), 32'(bus.pmp_rvalid), 32'h1);
         chk($sformatf("hold%0d_rdata", c), bus.pmp_rdata, 32'h88);
         if (c == 1) drive(12'h3B0, 3'd1, 5'h0, 32'h0, 2'b11, 1'b0);
         if (c == 2) bus.pmp_reg_en = 1'b0;
         if (c == 4) bus.pmp_rrsp = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      chk("hold_rvalid_off", 32'(bus.pmp_rvalid), 32'h0);
      chk("hold_rdata_off", bus.pmp_rdata, 32'h0);
      chk("stray_addr0", pmp_addr_o[31:0], 32'h1234_5678);

      // asynchronous reset while a response is outstanding
      drive(12'h3B0, 3'd2, 5'h0, 32'h0, 2'b10, 1'b0);
      @(negedge clk);
      bus.pmp_reg_en = 1'b0;
      chk("prerst_rdata", bus.pmp_rdata, 32'h1234_5678);
      #2 rst = 1'b1;
      #1;
      chk("midrst_rvalid", 32'(bus.pmp_rvalid), 32'h0);
      chk("midrst_rdata", bus.pmp_rdata, 32'h0);
      chk("midrst_act", 32'(bus.pmp_act_rsp), 32'h0);
      chk("midrst_cfg0", pmp_cfg_o[31:0], 32'h0);
      chk("midrst_addr0", pmp_addr_o[31:0], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.pmp_rrsp = 1'b1;
      @(negedge clk);
      drive(12'h3B0, 3'd1, 5'h0, 32'h0000_CAFE, 2'b11, 1'b1);
      @(negedge clk);
      bus.pmp_reg_en = 1'b0;
      chk("postrst_rvalid", 32'(bus.pmp_rvalid), 32'h1);
      chk("postrst_rdata", bus.pmp_rdata, 32'h0);
      @(negedge clk);
      chk("postrst_addr0", pmp_addr_o[31:0], 32'h0000_CAFE);
      chk("postrst_rvalid_off", 32'(bus.pmp_rvalid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
